// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: latches floor calls for a 4-floor lift, picks the next target with a
// SCAN policy and times a door-open dwell at each served floor.
// Optional: define DOOR_HOLD_EN to add i_door_hold, which keeps the door open while asserted.
module lift_call_scheduler #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned DWELL_W      = 8
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_call_req,
    input  logic [1:0] i_lift_state,
`ifdef DOOR_HOLD_EN
    input  logic       i_door_hold,
`endif
    output logic [1:0] o_floor,
    output logic       o_busy,
    output logic       o_door_open,
    output logic       o_dir,
    output logic [3:0] o_pending
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StMove = 2'b01,
        StDoor = 2'b10
    } state_t;

    localparam logic [DWELL_W-1:0] DwellLoad = DWELL_W'(DWELL_CYCLES - 1);

    state_t               r_state;
    logic   [1:0]         r_floor;
    logic                 r_dir;
    logic   [3:0]         r_pending;
    logic   [DWELL_W-1:0] r_dwell;

    state_t               w_state_d;
    logic   [1:0]         w_floor_d;
    logic                 w_dir_d;
    logic   [3:0]         w_pending_d;
    logic   [DWELL_W-1:0] w_dwell_d;
    logic   [3:0]         w_clear;
    logic   [3:0]         w_req_all;
    logic                 w_hold;

    logic                 w_up_found;
    logic   [1:0]         w_up_tgt;
    logic                 w_dn_found;
    logic   [1:0]         w_dn_tgt;
    logic                 w_have_tgt;
    logic   [1:0]         w_tgt;
    logic                 w_dir_next;

    // New calls act on the same edge they are latched.
    assign w_req_all = r_pending | i_call_req;

`ifdef DOOR_HOLD_EN
    assign w_hold = i_door_hold;
`else
    assign w_hold = 1'b0;
`endif

    // Nearest call above and below the current floor; the strict compares exclude the
    // current floor itself.
    always_comb begin
        w_up_found = 1'b0;
        w_up_tgt   = 2'd0;
        w_dn_found = 1'b0;
        w_dn_tgt   = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_req_all[i] && (2'(i) > i_lift_state)) begin
                w_up_found = 1'b1;
                w_up_tgt   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (w_req_all[i] && (2'(i) < i_lift_state)) begin
                w_dn_found = 1'b1;
                w_dn_tgt   = 2'(i);
            end
        end
    end

    // SCAN choice: keep sweeping in the current direction, reverse only when it is empty.
    always_comb begin
        w_tgt      = r_floor;
        w_dir_next = r_dir;
        w_have_tgt = w_up_found | w_dn_found;
        if (r_dir) begin
            if (w_up_found) begin
                w_tgt      = w_up_tgt;
                w_dir_next = 1'b1;
            end else if (w_dn_found) begin
                w_tgt      = w_dn_tgt;
                w_dir_next = 1'b0;
            end
        end else begin
            if (w_dn_found) begin
                w_tgt      = w_dn_tgt;
                w_dir_next = 1'b0;
            end else if (w_up_found) begin
                w_tgt      = w_up_tgt;
                w_dir_next = 1'b1;
            end
        end
    end

    // Next-state, target, direction, dwell and call-clear decisions.
    always_comb begin
        w_state_d = r_state;
        w_floor_d = r_floor;
        w_dir_d   = r_dir;
        w_dwell_d = r_dwell;
        w_clear   = 4'b0000;
        case (r_state)
            StIdle: begin
                if (w_req_all[i_lift_state]) begin
                    w_state_d               = StDoor;
                    w_clear[i_lift_state]   = 1'b1;
                    w_dwell_d               = DwellLoad;
                end else if (w_have_tgt) begin
                    w_state_d = StMove;
                    w_floor_d = w_tgt;
                    w_dir_d   = w_dir_next;
                end
            end
            StMove: begin
                if (i_lift_state == r_floor) begin
                    w_state_d          = StDoor;
                    w_clear[r_floor]   = 1'b1;
                    w_dwell_d          = DwellLoad;
                end else if (r_dir && w_up_found && (w_up_tgt < r_floor)) begin
                    // Pick up a call that lies on the way up.
                    w_floor_d = w_up_tgt;
                end else if (!r_dir && w_dn_found && (w_dn_tgt > r_floor)) begin
                    // Pick up a call that lies on the way down.
                    w_floor_d = w_dn_tgt;
                end
            end
            StDoor: begin
                // A call for the floor whose door is open is already served.
                w_clear[i_lift_state] = 1'b1;
                if (w_hold) begin
                    w_dwell_d = DwellLoad;
                end else if (r_dwell == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_dwell_d = r_dwell - DWELL_W'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        w_pending_d = w_req_all & ~w_clear;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= StIdle;
            r_floor   <= 2'd0;
            r_dir     <= 1'b1;
            r_pending <= 4'b0000;
            r_dwell   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_floor   <= w_floor_d;
            r_dir     <= w_dir_d;
            r_pending <= w_pending_d;
            r_dwell   <= w_dwell_d;
        end
    end

    assign o_floor     = r_floor;
    assign o_dir       = r_dir;
    assign o_pending   = r_pending;
    assign o_busy      = (r_state == StMove);
    assign o_door_open = (r_state == StDoor);

endmodule
